// File: rtl/bus32_to16_bridge.sv
// Splits 32-bit core requests into up to two 16-bit narrow-bus phases and reassembles read data.
// Per-phase watchdog aborts a stalled phase, returning all-ones data and raising a sticky error flag.
module bus32_to16_bridge #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_addr,
  input  logic [31:0]       s_wdata,
  input  logic              s_wr,
  input  logic [3:0]        s_lane,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       s_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [15:0]       m_wdata,
  output logic              m_wr,
  output logic [1:0]        m_be,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic [15:0]       m_rdata,
  output logic              bus_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-3:0]   wa_q, wa_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [3:0]          lane_q, lane_d;
  logic [31:0]         acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
  logic                s_ready_q, s_ready_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [15:0]         m_wdata_q, m_wdata_d;
  logic                m_wr_q, m_wr_d;
  logic [1:0]          m_be_q, m_be_d;
  logic                m_valid_q, m_valid_d;
  logic                xfer, expire, set_err;
  logic                unused_addr;

  // Only the halfword-aligned part of the address below ADDR_W reaches the narrow bus.
  assign unused_addr = ^s_addr;

  assign xfer   = m_valid_q & m_ready;
  assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !xfer;

  always_comb begin
    state_d   = state_q;
    wa_d      = wa_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    set_err   = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wr_d    = m_wr_q;
    m_be_d    = m_be_q;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          wa_d    = s_addr[ADDR_W-1:2];
          wdata_d = s_wdata;
          wr_d    = s_wr;
          lane_d  = s_lane;
          acc_d   = 32'h0;
          if (|s_lane[1:0])      state_d = LO;
          else if (|s_lane[3:2]) state_d = HI;
          else                   state_d = DONE;
        end
      end
      LO: begin
        if (xfer) begin
          if (!wr_q) acc_d[15:0] = m_rdata;
          state_d = (|lane_q[3:2]) ? HI : DONE;
        end else if (expire) begin
          acc_d   = 32'hFFFF_FFFF;
          set_err = 1'b1;
          state_d = DONE;
        end
      end
      HI: begin
        if (xfer) begin
          if (!wr_q) acc_d[31:16] = m_rdata;
          state_d = DONE;
        end else if (expire) begin
          acc_d   = 32'hFFFF_FFFF;
          set_err = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus fields are registered from the state being entered, so they track the phase exactly.
    m_valid_d = (state_d == LO) || (state_d == HI);
    s_ready_d = (state_d == DONE);
    if (state_d == LO) begin
      m_addr_d  = {wa_d, 2'b00};
      m_be_d    = lane_d[1:0];
      m_wdata_d = wdata_d[15:0];
      m_wr_d    = wr_d;
    end else if (state_d == HI) begin
      m_addr_d  = {wa_d, 2'b10};
      m_be_d    = lane_d[3:2];
      m_wdata_d = wdata_d[31:16];
      m_wr_d    = wr_d;
    end

    if (m_valid_d && (state_d != state_q)) cnt_d = '0;
    else if (!xfer)                        cnt_d = cnt_q + 1'b1;
    else                                   cnt_d = cnt_q;

    bus_err_d = set_err | (bus_err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wa_q      <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      lane_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      s_ready_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wr_q    <= 1'b0;
      m_be_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wa_q      <= wa_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      s_ready_q <= s_ready_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wr_q    <= m_wr_d;
      m_be_q    <= m_be_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready = s_ready_q;
  assign s_rdata = acc_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wr    = m_wr_q;
  assign m_be    = m_be_q;
  assign m_valid = m_valid_q;
  assign bus_err = bus_err_q;

endmodule

// File: doc/bus32_to16_bridge.md
Name: bus32_to16_bridge

Overview:
- Sits directly downstream of the RV32IM core's memory port and consumes its 32-bit valid/ready requests (addr, wdata, wr, 4-bit byte-lane mask).
- Splits each request into up to two 16-bit transactions on the narrow system bus (SRAM/SDRAM side) and reassembles 32-bit read data.
- Includes a per-phase watchdog so a dead slave cannot hang the core.

Parameters:
ADDR_W, 24, width of downstream byte address; m_addr = low ADDR_W bits of the computed address
TIMEOUT, 1024, cycles allowed per downstream phase before abort; 0 disables the watchdog
CNT_W, 11, width of the watchdog counter; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_addr  in  32  upstream byte address; bits [1:0] ignored for access placement
s_wdata  in  32  upstream write data
s_wr  in  1  1 = write, 0 = read
s_lane  in  4  byte-lane mask; bit n = byte n of the word
s_valid  in  1  request valid
s_ready  out  1  one-cycle completion pulse
s_rdata  out  32  read data, valid while s_ready=1
m_addr  out  ADDR_W  downstream halfword byte address, bit 0 always 0
m_wdata  out  16  downstream write data
m_wr  out  1  downstream write strobe qualifier
m_be  out  2  downstream byte enables
m_valid  out  1  downstream request valid
m_ready  in  1  downstream completion; transfer occurs when m_valid & m_ready
m_rdata  in  16  downstream read data, sampled on the transfer cycle
bus_err  out  1  sticky timeout flag
err_clr  in  1  synchronous clear of bus_err

Behaviour:
- All outputs are registered. Reset values: s_ready=0, s_rdata=0, m_addr=0, m_wdata=0, m_wr=0, m_be=0, m_valid=0, bus_err=0. State is IDLE.
- Reset asserted mid-transaction abandons it immediately. No completion pulse is generated.
- States: IDLE, LO, HI, DONE.
- IDLE: when s_valid=1, latch s_addr, s_wdata, s_wr and s_lane; clear the rdata accumulator. Next state:
  - LO if lane[1:0]!=0;
  - else HI if lane[3:2]!=0;
  - else DONE (lane 0000: no downstream access, s_rdata=0).
- LO: m_addr = {addr[ADDR_W-1:2],2'b00}; m_be = lane[1:0]; m_wdata = wdata[15:0]; m_wr = wr; m_valid=1.
  - On transfer, acc[15:0] <= m_rdata (reads only).
  - Then go to HI if lane[3:2]!=0, else DONE.
  - m_valid may stay high across LO->HI; the fields change on the same edge.
- HI: m_addr = {addr[ADDR_W-1:2],2'b10}; m_be = lane[3:2]; m_wdata = wdata[31:16]; m_wr = wr; m_valid=1.
  - On transfer, acc[31:16] <= m_rdata. Then go to DONE.
- DONE: m_valid=0; s_ready=1 for exactly one cycle; s_rdata = acc (skipped halves read 0; writes return 0). Next state IDLE.
- Upstream rule: the master deasserts s_valid on the edge after it sees s_ready. The core's fetch/load/store sequencing guarantees this.
- Latency with a zero-wait slave, measured from the first IDLE cycle with s_valid=1 to s_ready: 3 cycles for two halves, 2 cycles for one half, 1 cycle for lane 0000.
- m_ready while m_valid=0 is ignored. m_rdata is never sampled outside a transfer.
- Watchdog:
  - The counter clears on entry to LO or HI and increments each cycle without a transfer.
  - If it reaches TIMEOUT-1 with no transfer: drop m_valid, set acc to 32'hFFFFFFFF, set bus_err, go to DONE. The remaining half is skipped.
  - If a transfer and expiry occur in the same cycle, the transfer wins.
  - TIMEOUT=0: never expires.
- bus_err: err_clr=1 clears it. If a new timeout occurs in the same cycle, set wins.
- Requests are never pipelined: at most one upstream request is in flight.

Test Plan:
1. Read, lane 1111, addr 0x00001004, slave returns 0xBEEF then 0xDEAD with zero wait -> m_addr 0x001004 then 0x001006, m_be 11/11, s_ready 3 cycles after s_valid, s_rdata 0xDEADBEEF.
2. Byte store, addr 0x0000200B, lane 1000, wdata 0x5A5A5A5A -> only HI phase issued: m_addr 0x00200A, m_be 10, m_wr=1, m_wdata 0x5A5A; s_ready after 2 cycles.
3. Halfword store, lane 0011, wdata 0x12345678, slave inserts 3 wait states -> single LO phase, m_wdata 0x5678, m_valid held 4 cycles, then exactly one s_ready pulse.
4. Lane 0000 request -> no m_valid assertion; s_ready on the next cycle with s_rdata 0.
5. TIMEOUT=8, slave never asserts m_ready on a 1111 read -> m_valid drops after 8 LO cycles, HI skipped, s_rdata 0xFFFFFFFF, bus_err=1. A later err_clr pulse returns bus_err to 0.
6. rst asserted while in HI with m_valid=1 -> all outputs 0 immediately. The next request after reset completes normally with correct data.
